// File: rtl/weather_tree_pkg.sv
// Shared types and constants for the weather decision-tree classifier.
package weather_tree_pkg;

  localparam int N_FEAT    = 4;
  localparam int FEAT_W    = 4;
  localparam int N_NODES   = 16;
  localparam int ADDR_W    = $clog2(N_NODES);
  localparam int CLASS_W   = 3;
  localparam int MAX_DEPTH = 8;
  localparam int SEL_W     = $clog2(N_FEAT);
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

  localparam logic [CLASS_W-1:0] ERR_CLASS   = {CLASS_W{1'b1}};
  localparam logic [CLASS_W-1:0] CLASS_SUNNY = 3'd0;
  localparam logic [CLASS_W-1:0] CLASS_RAINY = 3'd1;
  localparam logic [CLASS_W-1:0] CLASS_SNOWY = 3'd6;

  typedef struct packed {
    logic               leaf;
    logic [SEL_W-1:0]   feat_sel;
    logic [FEAT_W-1:0]  thresh;
    logic [ADDR_W-1:0]  left;
    logic [ADDR_W-1:0]  right;
    logic [CLASS_W-1:0] class_code;
  } node_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // An unloaded node is a leaf reporting the error class.
  localparam node_t NODE_RESET = '{
    leaf:       1'b1,
    feat_sel:   {SEL_W{1'b0}},
    thresh:     {FEAT_W{1'b0}},
    left:       {ADDR_W{1'b0}},
    right:      {ADDR_W{1'b0}},
    class_code: ERR_CLASS
  };

  function automatic logic [FEAT_W-1:0] feat_pick(
    input logic [N_FEAT*FEAT_W-1:0] vec,
    input logic [SEL_W-1:0]         sel
  );
    return vec[int'(sel)*FEAT_W +: FEAT_W];
  endfunction

  function automatic logic feat_sel_ok(input logic [SEL_W-1:0] sel);
    return (int'(sel) < N_FEAT);
  endfunction

endpackage

// File: rtl/weather_tree_engine_if.sv
// Handshake and configuration bus of weather_tree_engine.
// WTREE_DEPTH_OUT_EN adds the out_depth signal.
interface weather_tree_engine_if;
  import weather_tree_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_feat;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W-1:0]       out_class;
  logic                     out_err;
  logic                     cfg_we;
  logic [ADDR_W-1:0]        cfg_addr;
  logic                     cfg_leaf;
  logic [SEL_W-1:0]         cfg_feat_sel;
  logic [FEAT_W-1:0]        cfg_thresh;
  logic [ADDR_W-1:0]        cfg_left;
  logic [ADDR_W-1:0]        cfg_right;
  logic [CLASS_W-1:0]       cfg_class;
  logic                     cfg_busy;
`ifdef WTREE_DEPTH_OUT_EN
  logic [DEPTH_W-1:0]       out_depth;
`endif

  modport master (
    output in_valid, in_feat, out_ready,
    output cfg_we, cfg_addr, cfg_leaf, cfg_feat_sel, cfg_thresh, cfg_left, cfg_right, cfg_class,
    input  in_ready, out_valid, out_class, out_err, cfg_busy
`ifdef WTREE_DEPTH_OUT_EN
    , input out_depth
`endif
  );

  modport slave (
    input  in_valid, in_feat, out_ready,
    input  cfg_we, cfg_addr, cfg_leaf, cfg_feat_sel, cfg_thresh, cfg_left, cfg_right, cfg_class,
    output in_ready, out_valid, out_class, out_err, cfg_busy
`ifdef WTREE_DEPTH_OUT_EN
    , output out_depth
`endif
  );

endinterface

// File: rtl/wtree_node_table.sv
// Node table: register file with one synchronous write port and one combinational read port.
module wtree_node_table
  import weather_tree_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  node_t             wdata,
  input  logic [ADDR_W-1:0] raddr,
  output node_t             rdata
);

  node_t mem_r [N_NODES];

  // Table storage; reset returns every entry to an error leaf
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) begin
        mem_r[i] <= NODE_RESET;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/weather_tree_engine.sv
// Table-driven decision-tree classifier: walks one node per clock over a latched feature vector.
// Optional WTREE_DEPTH_OUT_EN build reports the number of internal nodes traversed.
module weather_tree_engine (
  input logic                  clk,
  input logic                  rst,
  weather_tree_engine_if.slave bus
);
  import weather_tree_pkg::*;

  state_t                   state_r, state_next_s;
  logic [N_FEAT*FEAT_W-1:0] feat_r, feat_next_s;
  logic [ADDR_W-1:0]        node_ptr_r, node_ptr_next_s;
  logic [DEPTH_W-1:0]       steps_r, steps_next_s, steps_inc_s;
  logic [CLASS_W-1:0]       class_r, class_next_s;
  logic                     err_r, err_next_s;
  logic                     in_ready_r, out_valid_r, busy_r;
  logic                     tbl_we_s;
  node_t                    wr_node_s, node_s;

  // Table writes are only taken while idle so a walk always sees a frozen table.
  assign tbl_we_s  = bus.cfg_we & (state_r == ST_IDLE);
  assign wr_node_s = '{
    leaf:       bus.cfg_leaf,
    feat_sel:   bus.cfg_feat_sel,
    thresh:     bus.cfg_thresh,
    left:       bus.cfg_left,
    right:      bus.cfg_right,
    class_code: bus.cfg_class
  };

  wtree_node_table u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we_s),
    .waddr (bus.cfg_addr),
    .wdata (wr_node_s),
    .raddr (node_ptr_r),
    .rdata (node_s)
  );

  assign steps_inc_s = steps_r + {{(DEPTH_W-1){1'b0}}, 1'b1};

  // Next-state and datapath decode for the walk
  always_comb begin
    state_next_s    = state_r;
    feat_next_s     = feat_r;
    node_ptr_next_s = node_ptr_r;
    steps_next_s    = steps_r;
    class_next_s    = class_r;
    err_next_s      = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_next_s    = ST_WALK;
          feat_next_s     = bus.in_feat;
          node_ptr_next_s = {ADDR_W{1'b0}};
          steps_next_s    = {DEPTH_W{1'b0}};
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WALK: begin
        if (node_s.leaf) begin
          class_next_s = node_s.class_code;
          err_next_s   = 1'b0;
          state_next_s = ST_DONE;
        end else if (!feat_sel_ok(node_s.feat_sel)) begin
          class_next_s = ERR_CLASS;
          err_next_s   = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          steps_next_s = steps_inc_s;
          if (feat_pick(feat_r, node_s.feat_sel) <= node_s.thresh) begin
            node_ptr_next_s = node_s.left;
          end else begin
            node_ptr_next_s = node_s.right;
          end
          // Depth limit also breaks any loop a bad table might contain.
          if (steps_inc_s == DEPTH_W'(MAX_DEPTH)) begin
            class_next_s = ERR_CLASS;
            err_next_s   = 1'b1;
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_WALK;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      feat_r      <= {(N_FEAT*FEAT_W){1'b0}};
      node_ptr_r  <= {ADDR_W{1'b0}};
      steps_r     <= {DEPTH_W{1'b0}};
      class_r     <= {CLASS_W{1'b0}};
      err_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      feat_r      <= feat_next_s;
      node_ptr_r  <= node_ptr_next_s;
      steps_r     <= steps_next_s;
      class_r     <= class_next_s;
      err_r       <= err_next_s;
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_class = class_r;
  assign bus.out_err   = err_r;
  assign bus.cfg_busy  = busy_r;

`ifdef WTREE_DEPTH_OUT_EN
  logic [DEPTH_W-1:0] depth_r;

  // Step count captured as the walk finishes, held alongside the class
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_r <= {DEPTH_W{1'b0}};
    end else if ((state_r == ST_WALK) && (state_next_s == ST_DONE)) begin
      depth_r <= steps_next_s;
    end else begin
      depth_r <= depth_r;
    end
  end

  assign bus.out_depth = depth_r;
`endif

endmodule

// File: tb/tb_weather_tree_engine.sv
// Scoreboard bench for weather_tree_engine: directed vectors, expected results queued at issue.
module tb_weather_tree_engine;
  import weather_tree_pkg::*;

  typedef struct {
    logic [CLASS_W-1:0] cls;
    logic               err;
    int                 at;
    int                 depth;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  weather_tree_engine_if bus();

  weather_tree_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic logic [15:0] fv(input int mx, input int mn, input int pr, input int w);
    return {w[3:0], pr[3:0], mn[3:0], mx[3:0]};
  endfunction

  task automatic wr(input int addr, input logic leaf, input int sel, input int thr,
                    input int l, input int r, input logic [CLASS_W-1:0] cls);
    @(negedge clk);
    bus.cfg_we       = 1'b1;
    bus.cfg_addr     = ADDR_W'(addr);
    bus.cfg_leaf     = leaf;
    bus.cfg_feat_sel = SEL_W'(sel);
    bus.cfg_thresh   = FEAT_W'(thr);
    bus.cfg_left     = ADDR_W'(l);
    bus.cfg_right    = ADDR_W'(r);
    bus.cfg_class    = cls;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  // lat < 0 means the latency is not checked for this vector
  task automatic send(input logic [15:0] feat, input logic [CLASS_W-1:0] cls, input logic err,
                      input int lat, input int depth);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_feat  = feat;
    n = 0;
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      fail_now("accept");
      bus.in_valid = 1'b0;
    end else begin
      e.cls   = cls;
      e.err   = err;
      e.at    = (lat < 0) ? -1 : cyc + 1 + lat;
      e.depth = depth;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("drain");
  endtask

  // Monitor: pops an expectation when a result appears, then checks it holds until consumed
  initial begin
    exp_t               e;
    logic               seen;
    logic [CLASS_W-1:0] held_cls;
    logic               held_err;
    seen     = 1'b0;
    held_cls = {CLASS_W{1'b0}};
    held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !bus.out_valid) begin
        seen = 1'b0;
      end else begin
        if (!seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: class %0d with empty queue", bus.out_class);
          end else begin
            e = exp_q.pop_front();
            chk("out_class", bus.out_class, e.cls);
            chk("out_err", bus.out_err, e.err);
            if (e.at >= 0) chk("latency_edge", cyc, e.at);
`ifdef WTREE_DEPTH_OUT_EN
            chk("out_depth", bus.out_depth, e.depth);
`endif
          end
          held_cls = bus.out_class;
          held_err = bus.out_err;
        end else begin
          chk("hold_class", bus.out_class, held_cls);
          chk("hold_err", bus.out_err, held_err);
        end
        chk("in_ready_in_done", bus.in_ready, 0);
      end
    end
  end

  initial begin
    int n;
    bus.in_valid     = 1'b0;
    bus.in_feat      = 16'h0000;
    bus.out_ready    = 1'b1;
    bus.cfg_we       = 1'b0;
    bus.cfg_addr     = 4'd0;
    bus.cfg_leaf     = 1'b0;
    bus.cfg_feat_sel = 2'd0;
    bus.cfg_thresh   = 4'd0;
    bus.cfg_left     = 4'd0;
    bus.cfg_right    = 4'd0;
    bus.cfg_class    = 3'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_class", bus.out_class, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_cfg_busy", bus.cfg_busy, 0);

    // Unloaded table: root is an error leaf
    send(fv(5, 0, 3, 1), ERR_CLASS, 1'b0, 1, 0);
    drain();

    // Weather tree: internal n0..n4, leaves n5 SUNNY, n6 RAINY, n7 SNOWY
    wr(0, 1'b0, 0, 8, 1, 2, 3'd0);
    wr(1, 1'b0, 2, 0, 5, 3, 3'd0);
    wr(3, 1'b0, 1, 0, 7, 6, 3'd0);
    wr(2, 1'b0, 0, 12, 4, 5, 3'd0);
    wr(4, 1'b0, 2, 0, 5, 6, 3'd0);
    wr(5, 1'b1, 0, 0, 0, 0, CLASS_SUNNY);
    wr(6, 1'b1, 0, 0, 0, 0, CLASS_RAINY);
    wr(7, 1'b1, 0, 0, 0, 0, CLASS_SNOWY);

    send(fv(5, 0, 3, 1), CLASS_SNOWY, 1'b0, 4, 3);
    send(fv(13, 0, 3, 1), CLASS_SUNNY, 1'b0, 3, 2);
    send(fv(8, 0, 3, 1), CLASS_SNOWY, 1'b0, 4, 3);
    send(fv(5, 2, 3, 1), CLASS_RAINY, 1'b0, 4, 3);
    send(fv(10, 0, 0, 1), CLASS_SUNNY, 1'b0, 4, 3);
    send(fv(10, 0, 5, 1), CLASS_RAINY, 1'b0, 4, 3);
    send(fv(0, 0, 0, 0), CLASS_SUNNY, 1'b0, 3, 2);
    send(fv(15, 15, 15, 15), CLASS_SUNNY, 1'b0, 3, 2);
    drain();

    // Writes during a walk must be dropped
    send(fv(5, 0, 3, 1), CLASS_SNOWY, 1'b0, 4, 3);
    @(negedge clk);
    chk("busy_in_walk", bus.cfg_busy, 1);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'd7;
    bus.cfg_leaf  = 1'b1;
    bus.cfg_class = CLASS_RAINY;
    repeat (3) @(negedge clk);
    bus.cfg_we = 1'b0;
    drain();
    send(fv(5, 0, 3, 1), CLASS_SNOWY, 1'b0, 4, 3);
    drain();

    // Output held while out_ready is low
    bus.out_ready = 1'b0;
    send(fv(13, 0, 3, 1), CLASS_SUNNY, 1'b0, 3, 2);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail_now("hold_wait");
    repeat (5) @(negedge clk);
    chk("hold_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    drain();

    // Self-loop at the root aborts on the depth limit
    wr(0, 1'b0, 0, 0, 0, 0, 3'd0);
    send(fv(0, 3, 2, 1), ERR_CLASS, 1'b1, -1, 8);
    drain();

    // Reset in the middle of a walk
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_feat  = fv(0, 0, 0, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("busy_before_rst", bus.cfg_busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_cfg_busy", bus.cfg_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_out_after_rst", bus.out_valid, 0);
    end
    send(fv(0, 0, 0, 0), ERR_CLASS, 1'b0, 1, 0);
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
